// File: rtl/trivium_host_drv.sv
// Host-side initiator for the bit-serial Trivium core: loads key/IV, waits for warm-up,
// then streams plaintext bytes bit-serially and reassembles the returned cipher bytes.
module trivium_host_drv #(
  parameter int unsigned RDY_TIMEOUT = 1200
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [79:0] key_i,
  input  logic [79:0] iv_i,
  input  logic        start_i,
  input  logic [7:0]  pt_dat_i,
  input  logic        pt_vld_i,
  input  logic        pt_last_i,
  output logic        pt_rdy_o,
  output logic [7:0]  ct_dat_o,
  output logic        ct_vld_o,
  output logic        busy_o,
  output logic        sess_rdy_o,
  output logic        err_o,
  output logic        core_n_rst_o,
  output logic        core_dat_o,
  output logic        core_get_dat_o,
  output logic        core_ld_keys_o,
  output logic        core_end_o,
  input  logic        core_dat_i,
  input  logic        core_ready_i
);

  typedef enum logic [2:0] {
    StIdle, StCrst, StKey, StWaitRdy, StStrm, StBurst, StErr
  } state_e;

  localparam logic [10:0] TimeoutLast = 11'(RDY_TIMEOUT - 1);

  state_e       state_q;
  logic [10:0]  cnt_q;
  logic [159:0] sh_q;
  logic [7:0]   pt_q;
  logic         last_q;
  logic [6:0]   ct_sh_q;
  logic         rstp_q;
  logic         pt_rdy_q, ct_vld_q, busy_q, sess_q, err_q;
  logic         dat_q, get_q, ld_q, end_q;
  logic [7:0]   ct_dat_q;

  // Outputs are registered one cycle ahead: each branch sets what the next cycle must show.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sh_q     <= '0;
      pt_q     <= '0;
      last_q   <= 1'b0;
      ct_sh_q  <= '0;
      rstp_q   <= 1'b0;
      pt_rdy_q <= 1'b0;
      ct_vld_q <= 1'b0;
      busy_q   <= 1'b0;
      sess_q   <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= 1'b0;
      get_q    <= 1'b0;
      ld_q     <= 1'b0;
      end_q    <= 1'b0;
      ct_dat_q <= '0;
    end else begin
      rstp_q   <= 1'b0;
      ct_vld_q <= 1'b0;
      end_q    <= 1'b0;
      ld_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            sh_q    <= {iv_i, key_i};
            rstp_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StCrst;
          end
        end
        StCrst: begin
          cnt_q   <= '0;
          get_q   <= 1'b1;
          dat_q   <= 1'b0;
          state_q <= StKey;
        end
        StKey: begin
          if (cnt_q < 11'd160) begin
            cnt_q <= cnt_q + 11'd1;
            dat_q <= sh_q[0];
            sh_q  <= sh_q >> 1;
            get_q <= (cnt_q < 11'd159);
            ld_q  <= (cnt_q == 11'd159);
          end else begin
            cnt_q   <= '0;
            dat_q   <= 1'b0;
            get_q   <= 1'b0;
            state_q <= StWaitRdy;
          end
        end
        StWaitRdy: begin
          if (core_ready_i) begin
            sess_q   <= 1'b1;
            pt_rdy_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StStrm;
          end else if (cnt_q == TimeoutLast) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StErr;
          end else begin
            cnt_q <= cnt_q + 11'd1;
          end
        end
        StStrm: begin
          // A re-key request wins over a plaintext handshake in the same cycle.
          if (start_i) begin
            sh_q     <= {iv_i, key_i};
            rstp_q   <= 1'b1;
            sess_q   <= 1'b0;
            pt_rdy_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= StCrst;
          end else if (pt_vld_i) begin
            pt_q     <= pt_dat_i;
            last_q   <= pt_last_i;
            cnt_q    <= '0;
            get_q    <= 1'b1;
            dat_q    <= 1'b0;
            pt_rdy_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= StBurst;
          end
        end
        StBurst: begin
          if (cnt_q < 11'd8) begin
            cnt_q <= cnt_q + 11'd1;
            dat_q <= pt_q[0];
            pt_q  <= pt_q >> 1;
            get_q <= (cnt_q < 11'd7);
            if (cnt_q != 11'd0) begin
              ct_sh_q <= {core_dat_i, ct_sh_q[6:1]};
            end
          end else begin
            ct_dat_q <= {core_dat_i, ct_sh_q};
            ct_vld_q <= 1'b1;
            end_q    <= last_q;
            dat_q    <= 1'b0;
            pt_rdy_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StStrm;
          end
        end
        StErr: begin
          if (start_i) begin
            sh_q    <= {iv_i, key_i};
            err_q   <= 1'b0;
            rstp_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StCrst;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign core_n_rst_o   = ~(rst_i | rstp_q);
  assign pt_rdy_o       = pt_rdy_q;
  assign ct_dat_o       = ct_dat_q;
  assign ct_vld_o       = ct_vld_q;
  assign busy_o         = busy_q;
  assign sess_rdy_o     = sess_q;
  assign err_o          = err_q;
  assign core_dat_o     = dat_q;
  assign core_get_dat_o = get_q;
  assign core_ld_keys_o = ld_q;
  assign core_end_o     = end_q;

endmodule

// File: tb/tb_trivium_host_drv.sv
// Self-checking bench for trivium_host_drv with a behavioural core model that XORs a
// keystream table onto each consumed bit and raises ready a fixed delay after key load.
module tb_trivium_host_drv;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [79:0] key_i = '0;
  logic [79:0] iv_i = '0;
  logic        start_i = 1'b0;
  logic [7:0]  pt_dat_i = '0;
  logic        pt_vld_i = 1'b0;
  logic        pt_last_i = 1'b0;
  logic        pt_rdy_o, ct_vld_o, busy_o, sess_rdy_o, err_o;
  logic [7:0]  ct_dat_o;
  logic        core_n_rst_o, core_dat_o, core_get_dat_o, core_ld_keys_o, core_end_o;
  logic        core_dat_i;
  logic        core_ready_i = 1'b0;

  int          checks = 0;
  int          errors = 0;

  // Core model state
  logic [1023:0] ks = '0;
  logic [9:0]    ks_n = '0;
  logic [9:0]    exp_n = '0;
  logic          prev_get = 1'b0;
  logic          rdy_en = 1'b1;
  int            rdy_cnt = 0;

  always #5 clk = ~clk;

  trivium_host_drv #(.RDY_TIMEOUT(1200)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .key_i          (key_i),
    .iv_i           (iv_i),
    .start_i        (start_i),
    .pt_dat_i       (pt_dat_i),
    .pt_vld_i       (pt_vld_i),
    .pt_last_i      (pt_last_i),
    .pt_rdy_o       (pt_rdy_o),
    .ct_dat_o       (ct_dat_o),
    .ct_vld_o       (ct_vld_o),
    .busy_o         (busy_o),
    .sess_rdy_o     (sess_rdy_o),
    .err_o          (err_o),
    .core_n_rst_o   (core_n_rst_o),
    .core_dat_o     (core_dat_o),
    .core_get_dat_o (core_get_dat_o),
    .core_ld_keys_o (core_ld_keys_o),
    .core_end_o     (core_end_o),
    .core_dat_i     (core_dat_i),
    .core_ready_i   (core_ready_i)
  );

  // A bit is consumed in the cycle after get was high; cipher = data ^ keystream bit.
  assign core_dat_i = core_dat_o ^ ks[ks_n];

  always @(posedge clk) begin
    prev_get <= core_get_dat_o;
    if (prev_get) ks_n <= ks_n + 10'd1;
  end

  always @(posedge clk) begin
    if (!core_n_rst_o) begin
      core_ready_i <= 1'b0;
      rdy_cnt      <= 0;
    end else if (core_ld_keys_o) begin
      rdy_cnt <= 1;
    end else if (rdy_cnt != 0) begin
      if (rdy_en && rdy_cnt == 1153) core_ready_i <= 1'b1;
      rdy_cnt <= rdy_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic kick_start(input logic [79:0] k, input logic [79:0] v);
    key_i   = k;
    iv_i    = v;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Entered at the CRST cycle; leaves at the first WAIT_RDY cycle.
  task automatic key_phase(input logic [79:0] k, input logic [79:0] v);
    logic [3:0] e;
    checks++;
    if ({core_n_rst_o, busy_o} !== 2'b01) begin
      $display("FAIL crst n_rst/busy got=%b want=01", {core_n_rst_o, busy_o});
      errors++;
    end
    tick();
    for (int s = 0; s <= 160; s++) begin
      e[3] = (s < 160);
      if (s == 0) e[2] = 1'b0;
      else if (s <= 80) e[2] = k[s-1];
      else e[2] = v[s-81];
      e[1] = (s == 160);
      e[0] = 1'b0;
      checks++;
      if ({core_get_dat_o, core_dat_o, core_ld_keys_o, ct_vld_o} !== e) begin
        $display("FAIL key_bit s=%0d get/dat/ld/ctv got=%b want=%b", s,
                 {core_get_dat_o, core_dat_o, core_ld_keys_o, ct_vld_o}, e);
        errors++;
      end
      tick();
    end
    checks++;
    if ({busy_o, core_get_dat_o, core_ld_keys_o} !== 3'b100) begin
      $display("FAIL wait_entry busy/get/ld got=%b want=100",
               {busy_o, core_get_dat_o, core_ld_keys_o});
      errors++;
    end
  endtask

  task automatic wait_ready(input int exp_cycles);
    int n = 0;
    while (sess_rdy_o !== 1'b1 && n < 1400) begin
      tick();
      n++;
    end
    checks++;
    if (n != exp_cycles) begin
      $display("FAIL warmup_cycles got=%0d want=%0d", n, exp_cycles);
      errors++;
    end
    checks++;
    if ({pt_rdy_o, err_o, busy_o} !== 3'b100) begin
      $display("FAIL sess_flags pt_rdy/err/busy got=%b want=100", {pt_rdy_o, err_o, busy_o});
      errors++;
    end
  endtask

  task automatic send_byte(input logic [7:0] pt, input logic last);
    logic [7:0] exp;
    logic [2:0] e;
    logic [9:0] idx;
    for (int i = 0; i < 8; i++) begin
      idx    = exp_n + 10'(i);
      exp[i] = pt[i] ^ ks[idx];
    end
    exp_n = exp_n + 10'd8;
    checks++;
    if (pt_rdy_o !== 1'b1) begin
      $display("FAIL pt_rdy_before got=%b want=1", pt_rdy_o);
      errors++;
    end
    pt_dat_i  = pt;
    pt_last_i = last;
    pt_vld_i  = 1'b1;
    tick();
    pt_vld_i  = 1'b0;
    pt_last_i = 1'b0;
    for (int b = 0; b <= 8; b++) begin
      e[2] = (b < 8);
      e[1] = (b == 0) ? 1'b0 : pt[b-1];
      e[0] = 1'b0;
      checks++;
      if ({core_get_dat_o, core_dat_o, ct_vld_o} !== e) begin
        $display("FAIL burst b=%0d get/dat/ctv got=%b want=%b", b,
                 {core_get_dat_o, core_dat_o, ct_vld_o}, e);
        errors++;
      end
      tick();
    end
    checks++;
    if ({ct_vld_o, ct_dat_o, core_end_o, pt_rdy_o} !== {1'b1, exp, last, 1'b1}) begin
      $display("FAIL ct_out vld/dat/end/rdy got=%b/%h/%b/%b want=1/%h/%b/1",
               ct_vld_o, ct_dat_o, core_end_o, pt_rdy_o, exp, last);
      errors++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    checks++;
    if (core_n_rst_o !== 1'b0) begin
      $display("FAIL reset_n_rst got=%b want=0", core_n_rst_o);
      errors++;
    end
    checks++;
    if ({pt_rdy_o, ct_dat_o, ct_vld_o, busy_o, sess_rdy_o, err_o, core_dat_o, core_get_dat_o,
         core_ld_keys_o, core_end_o} !== 17'd0) begin
      $display("FAIL reset_outputs got nonzero want=0");
      errors++;
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (core_n_rst_o !== 1'b1) begin
      $display("FAIL reset_release_n_rst got=%b want=1", core_n_rst_o);
      errors++;
    end
    tick();
  endtask

  task automatic test_key_load();
    kick_start(80'h1, 80'h8000_0000_0000_0000_0000);
    key_phase(80'h1, 80'h8000_0000_0000_0000_0000);
  endtask

  task automatic test_warmup();
    wait_ready(1154);
  endtask

  task automatic test_byte_a5();
    ks    = '1;
    exp_n = ks_n;
    send_byte(8'hA5, 1'b0);
  endtask

  task automatic test_back_to_back();
    int c;
    ks        = '0;
    exp_n     = ks_n;
    pt_dat_i  = 8'h00;
    pt_last_i = 1'b0;
    pt_vld_i  = 1'b1;
    tick();
    pt_dat_i  = 8'hFF;
    pt_last_i = 1'b1;
    for (int m = 0; m < 2; m++) begin
      c = 1;
      while (pt_rdy_o !== 1'b1 && c < 20) begin
        tick();
        c++;
      end
      checks++;
      if (c != 10) begin
        $display("FAIL b2b_spacing m=%0d got=%0d want=10", m, c);
        errors++;
      end
      checks++;
      if ({ct_vld_o, ct_dat_o, core_end_o} !== {1'b1, (m == 0) ? 8'h00 : 8'hFF, m == 1}) begin
        $display("FAIL b2b_ct m=%0d vld/dat/end got=%b/%h/%b", m, ct_vld_o, ct_dat_o,
                 core_end_o);
        errors++;
      end
      tick();
      if (m == 0) begin
        pt_vld_i  = 1'b0;
        pt_last_i = 1'b0;
      end
    end
    exp_n = exp_n + 10'd16;
  endtask

  task automatic test_random_bytes();
    for (int i = 0; i < 32; i++) ks[i*32 +: 32] = $urandom();
    exp_n = ks_n;
    for (int i = 0; i < 6; i++) begin
      send_byte(8'($urandom()), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic test_rekey_priority();
    logic [95:0] r;
    logic [79:0] k2, v2;
    r  = {$urandom(), $urandom(), $urandom()};
    k2 = r[79:0];
    r  = {$urandom(), $urandom(), $urandom()};
    v2 = r[79:0];
    pt_dat_i = 8'h3C;
    pt_vld_i = 1'b1;
    kick_start(k2, v2);
    pt_vld_i = 1'b0;
    checks++;
    if ({core_n_rst_o, sess_rdy_o, pt_rdy_o, busy_o, core_get_dat_o} !== 5'b00010) begin
      $display("FAIL rekey_crst n_rst/sess/rdy/busy/get got=%b want=00010",
               {core_n_rst_o, sess_rdy_o, pt_rdy_o, busy_o, core_get_dat_o});
      errors++;
    end
    key_phase(k2, v2);
    wait_ready(1154);
  endtask

  task automatic test_reset_mid_burst();
    pt_dat_i = 8'($urandom());
    pt_vld_i = 1'b1;
    tick();
    pt_vld_i = 1'b0;
    repeat (4) tick();
    rst_i = 1'b1;
    #1;
    checks++;
    if (core_n_rst_o !== 1'b0) begin
      $display("FAIL midburst_n_rst got=%b want=0", core_n_rst_o);
      errors++;
    end
    tick();
    checks++;
    if ({pt_rdy_o, ct_dat_o, ct_vld_o, busy_o, sess_rdy_o, err_o, core_dat_o, core_get_dat_o,
         core_ld_keys_o, core_end_o, core_n_rst_o} !== 18'd0) begin
      $display("FAIL midburst_outputs got nonzero want=0");
      errors++;
    end
    rst_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({ct_vld_o, busy_o, core_get_dat_o, core_n_rst_o} !== 4'b0001) begin
        $display("FAIL post_reset i=%0d ctv/busy/get/n_rst got=%b want=0001", i,
                 {ct_vld_o, busy_o, core_get_dat_o, core_n_rst_o});
        errors++;
      end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    rdy_en = 1'b0;
    kick_start(80'h1234_5678_9ABC_DEF0_1357, 80'h2468_ACE0_1357_9BDF_0246);
    key_phase(80'h1234_5678_9ABC_DEF0_1357, 80'h2468_ACE0_1357_9BDF_0246);
    while (err_o !== 1'b1 && n < 1400) begin
      tick();
      n++;
    end
    checks++;
    if (n != 1200) begin
      $display("FAIL timeout_cycles got=%0d want=1200", n);
      errors++;
    end
    repeat (3) tick();
    checks++;
    if ({err_o, busy_o, sess_rdy_o, core_get_dat_o, core_ld_keys_o, core_end_o} !== 6'b100000)
    begin
      $display("FAIL err_hold err/busy/sess/get/ld/end got=%b want=100000",
               {err_o, busy_o, sess_rdy_o, core_get_dat_o, core_ld_keys_o, core_end_o});
      errors++;
    end
    rdy_en = 1'b1;
    kick_start(80'hFEDC, 80'hBA98);
    checks++;
    if (err_o !== 1'b0) begin
      $display("FAIL err_clear got=%b want=0", err_o);
      errors++;
    end
    key_phase(80'hFEDC, 80'hBA98);
    wait_ready(1154);
    exp_n = ks_n;
    send_byte(8'($urandom()), 1'b1);
  endtask

  initial begin
    test_reset();
    test_key_load();
    test_warmup();
    test_byte_a5();
    test_back_to_back();
    test_random_bytes();
    test_rekey_priority();
    test_reset_mid_burst();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trivium_host_drv.md
Name: trivium_host_drv

Overview:
- Host-side initiator for the serial Trivium core: the transmitting end of its key/IV/data bit-serial protocol.
- Takes a parallel 80-bit key and 80-bit IV, serializes them LSB first (key then IV), issues the load command, waits for the core's ready flag, then streams plaintext bytes bit-serially and reassembles the returned cipher bits into bytes.
- Sits between a byte-wide host bus and the core.

Parameters:
RDY_TIMEOUT, 1200, max cycles in WAIT_RDY before err_o; counter width 11 bits.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
key_i  in  80  key, sampled on start_i accept
iv_i  in  80  IV, sampled on start_i accept
start_i  in  1  begin new session (key load + warm-up)
pt_dat_i  in  8  plaintext byte
pt_vld_i  in  1  plaintext valid
pt_last_i  in  1  marks last byte of a message (qualified by pt_vld_i)
pt_rdy_o  out  1  driver accepts plaintext byte
ct_dat_o  out  8  cipher byte, bit0 = first serial bit
ct_vld_o  out  1  one-cycle cipher byte strobe (no backpressure)
busy_o  out  1  session setup or byte burst in progress
sess_rdy_o  out  1  core warmed up, stream accepted
err_o  out  1  sticky ready-timeout error
core_n_rst_o  out  1  core reset, active low
core_dat_o  out  1  serial bit to core
core_get_dat_o  out  1  core get-data strobe
core_ld_keys_o  out  1  core load-key strobe
core_end_o  out  1  core end-of-stream strobe
core_dat_i  in  1  serial cipher bit from core (combinational in core's process cycle)
core_ready_i  in  1  core initialized flag

Behaviour:
- Clock/reset: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset values: all outputs 0 except core_n_rst_o. core_n_rst_o = ~(rst_i | rstp_r); it is low throughout rst_i. State goes to IDLE.
- Core protocol rule (both phases): core_get_dat_o leads data by one cycle. A bit presented at cycle k is consumed only if core_get_dat_o was high at k-1.
- States: IDLE, CRST, KEY, WAIT_RDY, STRM, BURST, ERR.
- IDLE: start_i=1 -> capture {iv_i,key_i} into a 160-bit shift register; go to CRST.
- CRST (1 cycle): rstp_r=1, so core_n_rst_o is low. Go to KEY with s=0.
- KEY, cycles s=0..160:
  - core_get_dat_o=1 for s=0..159.
  - core_dat_o = bit s-1 of {iv,key} for s=1..160 (key[0] first, iv[79] last); 0 at s=0.
  - core_ld_keys_o=1 only at s=160, with core_get_dat_o=0.
  - Then go to WAIT_RDY with timer cleared.
- WAIT_RDY:
  - core_ready_i=1 -> STRM, sess_rdy_o=1.
  - Timer reaches RDY_TIMEOUT -> ERR, err_o=1.
  - Nominal core delay is 1154 cycles after the ld_keys cycle.
- STRM:
  - pt_rdy_o=1, busy_o=0.
  - start_i has priority over a plaintext handshake in the same cycle: re-key via CRST, sess_rdy_o=0, byte not taken.
  - Otherwise pt_vld_i&pt_rdy_o -> latch byte and last flag, go to BURST with b=0.
- BURST, cycles b=0..8:
  - core_get_dat_o=1 for b=0..7.
  - core_dat_o = pt bit b-1 for b=1..8.
  - core_dat_i sampled into ct bit b-1 at b=1..8.
  - Cycle after b=8: ct_vld_o=1 with the full byte; core_end_o=1 in the same cycle if the last flag was set; return to STRM.
  - Burst length is exactly 9 cycles. Next handshake is possible the cycle ct_vld_o is high, so peak rate is 1 byte per 10 cycles.
- ERR: err_o held, all core strobes 0. start_i -> clear err_o, CRST.
- start_i is ignored during KEY, WAIT_RDY and BURST. busy_o=1 in CRST, KEY, WAIT_RDY and BURST.
- Keystream continuity: bytes after pt_last_i continue the same keystream. Only start_i re-keys.
- rst_i mid-burst: immediate return to IDLE, partial byte discarded, no ct_vld_o.

Test Plan:
- Key load: rst, start_i with key=80'h0…01, iv=80'h8000…0 -> core_get_dat_o high 160 cycles; core_dat_o=1 at s=1 and s=160 only; core_ld_keys_o single pulse at s=160.
- Warm-up: core model raises ready 1154 cycles after ld -> sess_rdy_o=1, pt_rdy_o=1, err_o=0. Model never raises ready -> err_o=1 exactly 1200 cycles after WAIT_RDY entry.
- Byte burst: pt=8'hA5, model core_dat_i = core_dat_o ^ 1 -> ct_vld_o pulse with ct_dat_o=8'h5A at burst cycle 9; core_dat_o bits 1,0,1,0,0,1,0,1.
- Back-to-back: pt_vld_i held with 8'h00, 8'hFF (pt_last_i on second), model core_dat_i = core_dat_o -> handshakes 10 cycles apart; ct 8'h00 then 8'hFF; core_end_o with second ct_vld_o only.
- Re-key and priority: start_i and pt_vld_i both high in STRM -> no byte accepted; core_n_rst_o low one cycle; new 161-cycle key phase.
- Reset mid-burst: rst_i at b=4 -> all outputs reset next cycle, core_n_rst_o low during rst_i, no ct_vld_o.
